// File: rtl/mem_access_sequencer_if.sv
// Avalon-MM-style word bus between the sequencer (master) and memory (slave).
// Signals:
//   avm_address       master -> slave  word address
//   avm_writedata     master -> slave  write data
//   avm_write         master -> slave  write request
//   avm_read          master -> slave  read request
//   avm_waitrequest   slave -> master  stall; the master holds its request while 1
//   avm_readdata      slave -> master  read data
//   avm_readdatavalid slave -> master  qualifies avm_readdata
interface mem_access_sequencer_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] avm_address;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_write;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address, avm_writedata, avm_write, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        input  avm_address, avm_writedata, avm_write, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Runs one memory operation (write, read or zero-fill clear) per rising edge
// of ioDone on an Avalon-MM-style master port.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   modeIn      00=clear, 01=read, 10=write, 11=no-op (latched at start)
//   addrIn      target word address (latched at start)
//   dataIn      write data (latched at start)
//   ioDone      start request, rising edge triggers when idle
//   memDone     1 = idle/ready, 0 = operation in progress
//   readData    last word read, held until the next read completes
//   readValid   one-cycle pulse when readData updates
//   busyMode    mode of the current operation, 11 when idle
//   avm         master side of the memory bus
module mem_access_sequencer #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CLEAR_LAST = (32'd1 << ADDR_W) - 32'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        modeIn,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              ioDone,
    output logic              memDone,
    output logic [DATA_W-1:0] readData,
    output logic              readValid,
    output logic [1:0]        busyMode,
    mem_access_sequencer_if.master avm
);
    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_IDLE  = 2'b11;
    localparam logic [ADDR_W-1:0] CLR_END = ADDR_W'(CLEAR_LAST);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        CLR_REQ,
        DONE
    } state_t;

    state_t            state;
    logic              ioDoneQ;
    logic [ADDR_W-1:0] clrCnt;
    logic              start;

    // Only an edge seen while idle starts an operation; others are dropped.
    assign start = ioDone & ~ioDoneQ & (state == IDLE);

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            ioDoneQ           <= 1'b1;   // ioDone held high through reset must not trigger
            clrCnt            <= '0;
            memDone           <= 1'b1;
            readData          <= '0;
            readValid         <= 1'b0;
            busyMode          <= MODE_IDLE;
            avm.avm_address   <= '0;
            avm.avm_writedata <= '0;
            avm.avm_write     <= 1'b0;
            avm.avm_read      <= 1'b0;
        end else begin
            ioDoneQ   <= ioDone;
            readValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        case (modeIn)
                            MODE_WRITE: begin
                                state             <= WR_REQ;
                                memDone           <= 1'b0;
                                busyMode          <= modeIn;
                                avm.avm_write     <= 1'b1;
                                avm.avm_address   <= addrIn;
                                avm.avm_writedata <= dataIn;
                            end
                            MODE_READ: begin
                                state           <= RD_REQ;
                                memDone         <= 1'b0;
                                busyMode        <= modeIn;
                                avm.avm_read    <= 1'b1;
                                avm.avm_address <= addrIn;
                            end
                            MODE_CLEAR: begin
                                state             <= CLR_REQ;
                                memDone           <= 1'b0;
                                busyMode          <= modeIn;
                                clrCnt            <= '0;
                                avm.avm_write     <= 1'b1;
                                avm.avm_address   <= '0;
                                avm.avm_writedata <= '0;
                            end
                            default: ;   // no-op mode: stay idle
                        endcase
                    end
                end
                WR_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        state         <= DONE;
                        avm.avm_write <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (!avm.avm_waitrequest) begin
                        state        <= RD_WAIT;
                        avm.avm_read <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (avm.avm_readdatavalid) begin
                        state     <= DONE;
                        readData  <= avm.avm_readdata;
                        readValid <= 1'b1;
                    end
                end
                CLR_REQ: begin
                    // Advance one address per accepted write; stop after CLR_END.
                    if (!avm.avm_waitrequest) begin
                        if (clrCnt == CLR_END) begin
                            state         <= DONE;
                            avm.avm_write <= 1'b0;
                        end else begin
                            clrCnt          <= clrCnt + 1'b1;
                            avm.avm_address <= clrCnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    memDone  <= 1'b1;
                    busyMode <= MODE_IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a small slave model (memory,
// programmable waitrequest, fixed read latency) advanced by the step task.
module tb_mem_access_sequencer;
    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned CLEAR_LAST = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        modeIn;
    logic [ADDR_W-1:0] addrIn;
    logic [DATA_W-1:0] dataIn;
    logic              ioDone;
    logic              memDone;
    logic [DATA_W-1:0] readData;
    logic              readValid;
    logic [1:0]        busyMode;

    mem_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

    mem_access_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_LAST(CLEAR_LAST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .modeIn(modeIn), .addrIn(addrIn),
        .dataIn(dataIn), .ioDone(ioDone), .memDone(memDone),
        .readData(readData), .readValid(readValid), .busyMode(busyMode),
        .avm(avm.master)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    logic [ADDR_W-1:0] logAddr[$];
    logic [DATA_W-1:0] logData[$];
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    int                rdCnt = 0;
    logic [ADDR_W-1:0] rdAddr = '0;

    // One clock: record what the slave accepts at this edge, then sample #1 after.
    task automatic step();
        bit wrAcc, rdAcc;
        wrAcc = rst_n && avm.avm_write && !avm.avm_waitrequest;
        rdAcc = rst_n && avm.avm_read && !avm.avm_waitrequest;
        if (wrAcc) begin
            mem[avm.avm_address] = avm.avm_writedata;
            logAddr.push_back(avm.avm_address);
            logData.push_back(avm.avm_writedata);
        end
        if (rdAcc) rdAddr = avm.avm_address;
        @(posedge clk);
        #1;
        avm.avm_readdatavalid = 1'b0;
        if (rdCnt > 0) begin
            rdCnt--;
            if (rdCnt == 0) begin
                avm.avm_readdatavalid = 1'b1;
                avm.avm_readdata = mem.exists(rdAddr) ? mem[rdAddr] : '0;
            end
        end
        if (rdAcc) rdCnt = 2;
    endtask

    task automatic start_op(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        modeIn = m;
        addrIn = a;
        dataIn = d;
        ioDone = 1'b1;
        step();
        ioDone = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (memDone) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ioDone = 1'b1;
        modeIn = 2'b10;
        addrIn = 25'h0000123;
        dataIn = 16'h5555;
        avm.avm_waitrequest = 1'b0;
        avm.avm_readdata = '0;
        avm.avm_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nVec++; if (memDone !== 1'b1) begin nErr++; $display("FAIL rst_memDone got=%b exp=1", memDone); end
        nVec++; if (readData !== 16'h0) begin nErr++; $display("FAIL rst_readData got=%h exp=0000", readData); end
        nVec++; if (readValid !== 1'b0) begin nErr++; $display("FAIL rst_readValid got=%b exp=0", readValid); end
        nVec++; if (busyMode !== 2'b11) begin nErr++; $display("FAIL rst_busyMode got=%b exp=11", busyMode); end
        nVec++; if (avm.avm_write !== 1'b0) begin nErr++; $display("FAIL rst_write got=%b exp=0", avm.avm_write); end
        nVec++; if (avm.avm_read !== 1'b0) begin nErr++; $display("FAIL rst_read got=%b exp=0", avm.avm_read); end
        nVec++; if (avm.avm_address !== 25'h0) begin nErr++; $display("FAIL rst_address got=%h exp=0", avm.avm_address); end
        nVec++; if (avm.avm_writedata !== 16'h0) begin nErr++; $display("FAIL rst_writedata got=%h exp=0", avm.avm_writedata); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            nVec++;
            if (memDone !== 1'b1 || avm.avm_write !== 1'b0 || avm.avm_read !== 1'b0) begin
                nErr++;
                $display("FAIL rst_release_idle cyc=%0d got memDone=%b wr=%b rd=%b exp 1/0/0",
                         i, memDone, avm.avm_write, avm.avm_read);
            end
        end
        ioDone = 1'b0;
        step();
        nVec++; if (logAddr.size() != 0) begin nErr++; $display("FAIL rst_no_writes got=%0d exp=0", logAddr.size()); end
    endtask

    task automatic test_write();
        logAddr.delete(); logData.delete();
        avm.avm_waitrequest = 1'b0;
        start_op(2'b10, 25'h1ABCDEF, 16'hBEEF);
        addrIn = '0; dataIn = '0; modeIn = 2'b01;
        nVec++;
        if (avm.avm_write !== 1'b1 || avm.avm_address !== 25'h1ABCDEF || avm.avm_writedata !== 16'hBEEF) begin
            nErr++;
            $display("FAIL wr_request got wr=%b a=%h d=%h exp 1/1abcdef/beef",
                     avm.avm_write, avm.avm_address, avm.avm_writedata);
        end
        nVec++; if (memDone !== 1'b0) begin nErr++; $display("FAIL wr_memDone_n1 got=%b exp=0", memDone); end
        nVec++; if (busyMode !== 2'b10) begin nErr++; $display("FAIL wr_busyMode got=%b exp=10", busyMode); end
        step();
        nVec++; if (avm.avm_write !== 1'b0) begin nErr++; $display("FAIL wr_deassert got=%b exp=0", avm.avm_write); end
        nVec++; if (memDone !== 1'b0) begin nErr++; $display("FAIL wr_memDone_n2 got=%b exp=0", memDone); end
        nVec++;
        if (logAddr.size() != 1 || logAddr[0] !== 25'h1ABCDEF || logData[0] !== 16'hBEEF) begin
            nErr++;
            $display("FAIL wr_accepted got n=%0d exp n=1 a=1abcdef d=beef", logAddr.size());
        end
        step();
        nVec++; if (memDone !== 1'b1) begin nErr++; $display("FAIL wr_memDone_n3 got=%b exp=1", memDone); end
        nVec++; if (busyMode !== 2'b11) begin nErr++; $display("FAIL wr_busyMode_idle got=%b exp=11", busyMode); end
        step();
        nVec++; if (logAddr.size() != 1) begin nErr++; $display("FAIL wr_single got=%0d exp=1", logAddr.size()); end
    endtask

    task automatic test_write_wait();
        logAddr.delete(); logData.delete();
        avm.avm_waitrequest = 1'b1;
        start_op(2'b10, 25'h0000055, 16'hA5A5);
        for (int c = 1; c <= 4; c++) begin
            addrIn = ADDR_W'(c * 3); dataIn = DATA_W'(c * 7);
            nVec++;
            if (avm.avm_write !== 1'b1 || avm.avm_address !== 25'h0000055 ||
                avm.avm_writedata !== 16'hA5A5 || memDone !== 1'b0) begin
                nErr++;
                $display("FAIL wrw_hold c=%0d got wr=%b a=%h d=%h done=%b exp 1/0000055/a5a5/0",
                         c, avm.avm_write, avm.avm_address, avm.avm_writedata, memDone);
            end
            if (c == 4) avm.avm_waitrequest = 1'b0;
            step();
        end
        nVec++;
        if (avm.avm_write !== 1'b0 || memDone !== 1'b0) begin
            nErr++;
            $display("FAIL wrw_done got wr=%b done=%b exp 0/0", avm.avm_write, memDone);
        end
        nVec++;
        if (logAddr.size() != 1 || logAddr[0] !== 25'h0000055 || logData[0] !== 16'hA5A5) begin
            nErr++;
            $display("FAIL wrw_accepted got n=%0d exp n=1 a=0000055 d=a5a5", logAddr.size());
        end
        step();
        nVec++; if (memDone !== 1'b1) begin nErr++; $display("FAIL wrw_memDone got=%b exp=1", memDone); end
    endtask

    task automatic test_read();
        bit ok;
        int pulses;
        logic [DATA_W-1:0] got;
        avm.avm_waitrequest = 1'b0;
        start_op(2'b10, 25'h0000010, 16'h1234);
        wait_idle(10, ok);
        logAddr.delete(); logData.delete();
        start_op(2'b01, 25'h0000010, 16'hFFFF);
        nVec++;
        if (avm.avm_read !== 1'b1 || avm.avm_write !== 1'b0 || avm.avm_address !== 25'h0000010) begin
            nErr++;
            $display("FAIL rd_request got rd=%b wr=%b a=%h exp 1/0/0000010",
                     avm.avm_read, avm.avm_write, avm.avm_address);
        end
        nVec++; if (busyMode !== 2'b01) begin nErr++; $display("FAIL rd_busyMode got=%b exp=01", busyMode); end
        step();
        nVec++; if (avm.avm_read !== 1'b0 || memDone !== 1'b0) begin nErr++; $display("FAIL rd_accept got rd=%b done=%b exp 0/0", avm.avm_read, memDone); end
        pulses = 0; got = '0; ok = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (readValid === 1'b1) begin pulses++; got = readData; end
            if (memDone === 1'b1) begin ok = 1'b1; break; end
        end
        nVec++; if (!ok) begin nErr++; $display("FAIL rd_timeout got memDone=%b exp=1", memDone); end
        nVec++; if (pulses != 1) begin nErr++; $display("FAIL rd_pulses got=%0d exp=1", pulses); end
        nVec++; if (got !== 16'h1234) begin nErr++; $display("FAIL rd_data got=%h exp=1234", got); end
        nVec++; if (logAddr.size() != 0) begin nErr++; $display("FAIL rd_no_write got=%0d exp=0", logAddr.size()); end
        avm.avm_readdata = 16'hDEAD;
        avm.avm_readdatavalid = 1'b1;
        step();
        nVec++;
        if (readValid !== 1'b0 || readData !== 16'h1234) begin
            nErr++;
            $display("FAIL rd_stray_valid got v=%b d=%h exp 0/1234", readValid, readData);
        end
    endtask

    task automatic test_noop();
        logAddr.delete(); logData.delete();
        start_op(2'b11, 25'h0000003, 16'h0007);
        for (int i = 0; i < 2; i++) begin
            nVec++;
            if (memDone !== 1'b1 || busyMode !== 2'b11 || avm.avm_write !== 1'b0 || avm.avm_read !== 1'b0) begin
                nErr++;
                $display("FAIL noop_idle cyc=%0d got done=%b bm=%b wr=%b rd=%b exp 1/11/0/0",
                         i, memDone, busyMode, avm.avm_write, avm.avm_read);
            end
            step();
        end
        nVec++; if (logAddr.size() != 0) begin nErr++; $display("FAIL noop_writes got=%0d exp=0", logAddr.size()); end
    endtask

    task automatic test_clear();
        bit ok;
        int bmBad;
        int n;
        logAddr.delete(); logData.delete();
        avm.avm_waitrequest = 1'($urandom_range(0, 1));
        start_op(2'b00, 25'h1ABCDEF, 16'hFFFF);
        nVec++;
        if (avm.avm_write !== 1'b1 || avm.avm_address !== 25'h0 || avm.avm_writedata !== 16'h0 || busyMode !== 2'b00) begin
            nErr++;
            $display("FAIL clr_first got wr=%b a=%h d=%h bm=%b exp 1/0/0/00",
                     avm.avm_write, avm.avm_address, avm.avm_writedata, busyMode);
        end
        ok = 1'b0; bmBad = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 2) begin ioDone = 1'b1; modeIn = 2'b10; addrIn = 25'h0000100; dataIn = 16'h1111; end
            if (i == 4) ioDone = 1'b0;
            if (busyMode !== 2'b00) bmBad++;
            avm.avm_waitrequest = 1'($urandom_range(0, 1));
            step();
            if (memDone === 1'b1) begin ok = 1'b1; break; end
        end
        nVec++; if (!ok) begin nErr++; $display("FAIL clr_timeout got memDone=%b exp=1", memDone); end
        nVec++; if (bmBad != 0) begin nErr++; $display("FAIL clr_busyMode got bad=%0d exp=0", bmBad); end
        nVec++; if (logAddr.size() != CLEAR_LAST + 1) begin nErr++; $display("FAIL clr_count got=%0d exp=%0d", logAddr.size(), CLEAR_LAST + 1); end
        n = (logAddr.size() < CLEAR_LAST + 1) ? logAddr.size() : CLEAR_LAST + 1;
        for (int i = 0; i < n; i++) begin
            nVec++;
            if (logAddr[i] !== ADDR_W'(i) || logData[i] !== 16'h0) begin
                nErr++;
                $display("FAIL clr_entry i=%0d got a=%h d=%h exp a=%h d=0000", i, logAddr[i], logData[i], ADDR_W'(i));
            end
        end
        avm.avm_waitrequest = 1'b0;
        repeat (3) step();
        nVec++;
        if (logAddr.size() != CLEAR_LAST + 1 || memDone !== 1'b1) begin
            nErr++;
            $display("FAIL clr_after got n=%0d done=%b exp n=%0d done=1", logAddr.size(), memDone, CLEAR_LAST + 1);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit ok;
        logAddr.delete(); logData.delete();
        avm.avm_waitrequest = 1'b0;
        start_op(2'b00, 25'h0, 16'h0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        nVec++;
        if (avm.avm_write !== 1'b0 || memDone !== 1'b1 || busyMode !== 2'b11 || avm.avm_address !== 25'h0) begin
            nErr++;
            $display("FAIL rstmid_outputs got wr=%b done=%b bm=%b a=%h exp 0/1/11/0",
                     avm.avm_write, memDone, busyMode, avm.avm_address);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        logAddr.delete(); logData.delete();
        start_op(2'b00, 25'h0, 16'h0);
        nVec++;
        if (avm.avm_write !== 1'b1 || avm.avm_address !== 25'h0) begin
            nErr++;
            $display("FAIL rstmid_restart got wr=%b a=%h exp 1/0", avm.avm_write, avm.avm_address);
        end
        wait_idle(50, ok);
        nVec++; if (!ok) begin nErr++; $display("FAIL rstmid_timeout got memDone=%b exp=1", memDone); end
        nVec++;
        if (logAddr.size() != CLEAR_LAST + 1 || logAddr[0] !== 25'h0 || logAddr[logAddr.size() - 1] !== ADDR_W'(CLEAR_LAST)) begin
            nErr++;
            $display("FAIL rstmid_clear got n=%0d exp n=%0d from 0 to %0d", logAddr.size(), CLEAR_LAST + 1, CLEAR_LAST);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_wait();
        test_read();
        test_noop();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Downstream of the keypad/switch I/O controller. It takes the operating mode, the 25-bit word address, the 16-bit write data and the ioDone strobe, and executes one memory operation per strobe on an Avalon-MM-style master port. The operation is one of: a single write, a single read, or a zero-fill clear of the whole address range. It returns memDone (ready) to the I/O controller and presents read data for the hex display.

Parameters:
ADDR_W, 25, word address width
DATA_W, 16, data width
CLEAR_LAST, 2**ADDR_W-1, last address written by clear; benches override to a small value

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
modeIn  in  2  00=clear, 01=read, 10=write, 11=no-op
addrIn  in  ADDR_W  target word address
dataIn  in  DATA_W  write data
ioDone  in  1  start request; the rising edge is the trigger
memDone  out  1  1 = idle/ready, 0 = operation in progress
readData  out  DATA_W  last word read; held until next read completes
readValid  out  1  one-cycle pulse when readData updates
busyMode  out  2  mode latched for the current operation; 11 when idle
avm_address  out  ADDR_W  master address
avm_writedata  out  DATA_W  master write data
avm_write  out  1  write request
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall; request held while 1
avm_readdata  in  DATA_W  slave read data
avm_readdatavalid  in  1  read data qualifier

Behaviour:
- Reset (async assert, sync release): state=IDLE; memDone=1; readData=0; readValid=0; busyMode=11; avm_write=avm_read=0; avm_address=0; avm_writedata=0; ioDone edge register=1, so an ioDone held high through reset does not trigger.
- Start:
  - start = ioDone & ~ioDone_q, sampled in IDLE only.
  - Edges in any other state are ignored and not queued.
  - modeIn, addrIn and dataIn are latched at start. Later input changes have no effect.
  - Start with modeIn=11: no transaction, state stays IDLE, memDone stays 1.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, CLR_REQ, DONE.
- IDLE -> WR_REQ / RD_REQ / CLR_REQ on start for mode 10 / 01 / 00. memDone drops to 0 the cycle after the start edge.
- WR_REQ:
  - Drive avm_write=1, avm_address=latched addr, avm_writedata=latched data.
  - Hold every signal stable while waitrequest=1.
  - On waitrequest=0 the write is accepted: go to DONE and deassert avm_write the next cycle.
- RD_REQ:
  - Drive avm_read=1 with the latched address; hold while waitrequest=1.
  - On waitrequest=0, go to RD_WAIT with avm_read=0.
- RD_WAIT:
  - On avm_readdatavalid=1: capture readData=avm_readdata, pulse readValid for 1 cycle, go to DONE.
  - readdatavalid is ignored in every other state.
- CLR_REQ:
  - Internal counter starts at 0. Drive avm_write=1, avm_writedata=0, avm_address=counter.
  - Each accepted write (waitrequest=0) increments the counter.
  - The write accepted at CLEAR_LAST goes to DONE. The counter never wraps past CLEAR_LAST.
  - With zero wait states, one write per cycle.
- DONE: one cycle with memDone=0 and no request, then IDLE with memDone=1 and busyMode=11.
- Latency with zero wait states: start edge sampled at cycle N, request at N+1, accepted at N+1, DONE at N+2, memDone=1 at N+3. A read adds the slave read latency.
- Reset mid-operation: outputs return to reset values immediately. A pending request is dropped and the clear counter returns to 0.
- busyMode = latched mode from the cycle after start until DONE exits.

Test Plan:
- Reset with ioDone=1 held, then release -> no avm_write/avm_read; memDone=1 throughout.
- modeIn=10, addrIn=0x1ABCDEF, dataIn=0xBEEF, ioDone rising, waitrequest=0 -> avm_write high exactly one cycle with those values; memDone 0 for 2 cycles, then 1.
- Same write with waitrequest=1 for 3 cycles -> avm_write, address and data stable for 4 cycles; memDone returns 1 two cycles after acceptance.
- Write 0x1234 to 0x000010, then modeIn=01 read of 0x000010 with a 2-cycle readdatavalid latency model -> readData=0x1234, readValid pulses once, memDone 1 afterwards.
- CLEAR_LAST=7, modeIn=00, random waitrequest -> exactly 8 accepted writes to addresses 0..7 in order, all data 0; no 9th write; memDone=1 after.
- A second ioDone edge and modeIn changes mid-clear -> ignored. Assert rst_n mid-clear -> avm_write=0 immediately, memDone=1, next clear restarts at address 0.
